// File: rtl/timer_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : timer_irq_ctrl
// Brief   : Edge-latched, masked, fixed-priority interrupt controller for the
//           8-bit timer's overflow/underflow flags, with an APB-style register
//           bus and an irq/irq_ack handshake.
// Revision: 1.0 - initial release
// ============================================================================
module timer_irq_ctrl (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr,
    input  logic       ovf_flag,
    input  logic       udf_flag,
    output logic       irq,
    input  logic       irq_ack
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ASSERT = 2'd1;
    localparam logic [1:0] c_HOLD   = 2'd2;

    localparam logic [7:0] c_ADDR_IER  = 8'h00;
    localparam logic [7:0] c_ADDR_IPR  = 8'h01;
    localparam logic [7:0] c_ADDR_IVR  = 8'h02;
    localparam logic [7:0] c_ADDR_ICNT = 8'h03;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [1:0] r_flag_q;
    logic [1:0] r_ier_en;
    logic       r_ier_gie;
    logic [1:0] r_pend;
    logic [1:0] r_ovr;
    logic [7:0] r_icnt;

    logic       w_access;
    logic       w_wr;
    logic       w_rd;
    logic [1:0] w_rise;
    logic [1:0] w_active;
    logic [7:0] w_ivr;
    logic [1:0] w_w1c_pend;
    logic [1:0] w_w1c_ovr;
    logic       w_ack_take;
    logic [1:0] w_ack_clr;
    logic [1:0] w_clr;
    logic       w_unused;

    assign w_access = psel & penable;
    assign w_wr     = w_access & pwrite;
    assign w_rd     = w_access & ~pwrite;

    assign w_rise   = {udf_flag, ovf_flag} & ~r_flag_q;
    assign w_active = r_pend & r_ier_en & {2{r_ier_gie}};

    // ovf wins over udf; vector value doubles as the one-hot pending mask
    always_comb begin
        w_ivr = 8'h00;
        if (w_active[0]) begin
            w_ivr = 8'h01;
        end else if (w_active[1]) begin
            w_ivr = 8'h02;
        end
    end

    assign w_w1c_pend = (w_wr && paddr == c_ADDR_IPR) ? pwdata[1:0] : 2'b00;
    assign w_w1c_ovr  = (w_wr && paddr == c_ADDR_IPR) ? pwdata[5:4] : 2'b00;
    assign w_ack_clr  = w_ack_take ? w_ivr[1:0] : 2'b00;
    assign w_clr      = w_w1c_pend | w_ack_clr;

    // A new rise always wins over a same-cycle clear; overrun only when the
    // earlier event is still genuinely outstanding.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_flag_q  <= 2'b00;
            r_ier_en  <= 2'b00;
            r_ier_gie <= 1'b0;
            r_pend    <= 2'b00;
            r_ovr     <= 2'b00;
            r_icnt    <= 8'h00;
        end else begin
            r_flag_q <= {udf_flag, ovf_flag};
            r_pend   <= w_rise | (r_pend & ~w_clr);
            r_ovr    <= (r_ovr & ~w_w1c_ovr) | (w_rise & r_pend & ~w_clr);
            if (w_wr && paddr == c_ADDR_IER) begin
                r_ier_en  <= pwdata[1:0];
                r_ier_gie <= pwdata[7];
            end
            if (w_wr && paddr == c_ADDR_ICNT) begin
                r_icnt <= 8'h00;
            end else if (w_ack_take && r_icnt != 8'hFF) begin
                r_icnt <= r_icnt + 8'h01;
            end
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_active != 2'b00) begin
                    w_state_nxt = c_ASSERT;
                end
            end
            c_ASSERT: begin
                if (irq_ack) begin
                    w_state_nxt = c_HOLD;
                end else if (w_active == 2'b00) begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_HOLD: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // irq is a direct decode of the state register, so it carries no comb path
    always_comb begin
        irq        = (r_state == c_ASSERT);
        w_ack_take = (r_state == c_ASSERT) && irq_ack;
    end

    always_comb begin
        prdata = 8'h00;
        if (w_rd) begin
            case (paddr)
                c_ADDR_IER:  prdata = {r_ier_gie, 5'b00000, r_ier_en};
                c_ADDR_IPR:  prdata = {2'b00, r_ovr, 2'b00, r_pend};
                c_ADDR_IVR:  prdata = w_ivr;
                c_ADDR_ICNT: prdata = r_icnt;
                default:     prdata = 8'h00;
            endcase
        end
    end

    assign pready   = 1'b1;
    assign pslverr  = presetn & w_access & (paddr > c_ADDR_ICNT);
    assign w_unused = &{1'b0, pwdata[6], pwdata[3:2]};

endmodule
`default_nettype wire

// File: tb/tb_timer_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_timer_irq_ctrl
// Brief   : Randomized self-checking bench for timer_irq_ctrl against a
//           behavioural register/interrupt model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_timer_irq_ctrl;

    logic       pclk = 1'b0;
    logic       presetn;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;
    logic       ovf_flag;
    logic       udf_flag;
    logic       irq;
    logic       irq_ack;

    int n_checks = 0;
    int n_errors = 0;

    timer_irq_ctrl dut (
        .pclk     (pclk),
        .presetn  (presetn),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .ovf_flag (ovf_flag),
        .udf_flag (udf_flag),
        .irq      (irq),
        .irq_ack  (irq_ack)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: contents after the next clock edge
    bit [7:0] m_ier;
    bit [1:0] m_pend;
    bit [1:0] m_ovr;
    bit [1:0] m_prev;
    int       m_icnt;
    bit       m_irq;
    bit       m_gap;

    task automatic model_reset();
        m_ier  = 8'h00;
        m_pend = 2'b00;
        m_ovr  = 2'b00;
        m_prev = 2'b00;
        m_icnt = 0;
        m_irq  = 1'b0;
        m_gap  = 1'b0;
    endtask

    function automatic bit [1:0] m_active();
        return m_ier[7] ? (m_pend & m_ier[1:0]) : 2'b00;
    endfunction

    function automatic logic [7:0] m_vector();
        bit [1:0] a;
        a = m_active();
        if (a[0]) return 8'h01;
        if (a[1]) return 8'h02;
        return 8'h00;
    endfunction

    function automatic logic [7:0] m_read(input logic [7:0] a);
        case (a)
            8'h00:   return m_ier;
            8'h01:   return {2'b00, m_ovr, 2'b00, m_pend};
            8'h02:   return m_vector();
            8'h03:   return 8'(m_icnt);
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_step();
        bit [1:0] act;
        bit [1:0] flags;
        bit [1:0] rise;
        bit [1:0] clr;
        bit [1:0] ackbits;
        bit       wr;
        bit       acked;
        act     = m_active();
        flags   = {udf_flag, ovf_flag};
        rise    = flags & ~m_prev;
        wr      = psel && penable && pwrite;
        acked   = m_irq && irq_ack;
        ackbits = 2'b00;
        if (acked) begin
            ackbits = m_vector() == 8'h01 ? 2'b01 : (m_vector() == 8'h02 ? 2'b10 : 2'b00);
            if (m_icnt < 255) m_icnt++;
        end
        clr = ackbits;
        if (wr && paddr == 8'h01) begin
            clr   = clr | pwdata[1:0];
            m_ovr = m_ovr & ~pwdata[5:4];
        end
        for (int i = 0; i < 2; i++) begin
            if (rise[i]) begin
                if (m_pend[i] && !clr[i]) m_ovr[i] = 1'b1;
                m_pend[i] = 1'b1;
            end else if (clr[i]) begin
                m_pend[i] = 1'b0;
            end
        end
        if (acked) begin
            m_irq = 1'b0;
            m_gap = 1'b1;
        end else if (m_irq) begin
            m_irq = (act != 2'b00);
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else begin
            m_irq = (act != 2'b00);
        end
        if (wr && paddr == 8'h00) m_ier = pwdata & 8'h83;
        if (wr && paddr == 8'h03) m_icnt = 0;
        m_prev = flags;
    endtask

    task automatic bus_idle();
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 8'h00;
        pwdata  = 8'h00;
        irq_ack = 1'b0;
    endtask

    task automatic check_bus();
        bit acc;
        acc = psel && penable;
        if (acc && !pwrite) chk("prdata", prdata, m_read(paddr));
        else                chk("prdata_idle", prdata, 8'h00);
        chk("pslverr", {7'b0, pslverr}, {7'b0, acc && (paddr > 8'h03)});
        chk("pready", {7'b0, pready}, 8'h01);
    endtask

    initial begin
        bit rst_req;
        rst_req  = 1'b0;
        presetn  = 1'b0;
        ovf_flag = 1'b0;
        udf_flag = 1'b0;
        bus_idle();
        model_reset();
        repeat (3) @(negedge pclk);
        chk("irq_in_reset", {7'b0, irq}, 8'h00);
        chk("pslverr_in_reset", {7'b0, pslverr}, 8'h00);
        chk("prdata_in_reset", prdata, 8'h00);
        presetn = 1'b1;

        // Reset contents plus one out-of-range read
        for (int a = 0; a < 5; a++) begin
            psel    = 1'b1;
            penable = 1'b1;
            pwrite  = 1'b0;
            paddr   = (a == 4) ? 8'h05 : 8'(a);
            #1;
            check_bus();
            model_step();
            @(negedge pclk);
        end
        bus_idle();

        for (int c = 0; c < 7000; c++) begin
            chk("irq", {7'b0, irq}, {7'b0, m_irq});
            if (c == 3000 || c == 5500) rst_req = 1'b1;
            if (rst_req && m_irq) begin
                rst_req = 1'b0;
                bus_idle();
                presetn = 1'b0;
                #1;
                chk("irq_async_drop", {7'b0, irq}, 8'h00);
                model_reset();
                @(negedge pclk);
                presetn = 1'b1;
                chk("irq_after_rst", {7'b0, irq}, 8'h00);
            end

            if ($urandom_range(0, 3) == 0) ovf_flag = ~ovf_flag;
            if ($urandom_range(0, 3) == 0) udf_flag = ~udf_flag;
            psel    = ($urandom_range(0, 1) == 1);
            penable = psel && ($urandom_range(0, 4) != 0);
            pwrite  = ($urandom_range(0, 1) == 1);
            paddr   = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
            pwdata  = 8'($urandom);
            if (paddr == 8'h00 && $urandom_range(0, 3) != 0) pwdata[7] = 1'b1;
            irq_ack = ($urandom_range(0, 2) == 0);
            // Keep ICNT clears out of phase one so saturation is reachable
            if (pwrite && paddr == 8'h03) begin
                if (c < 3000) pwrite = 1'b0;
                else          irq_ack = 1'b0;
            end
            #1;
            check_bus();
            model_step();
            @(negedge pclk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
